sub_bytes_seq: RTL and testbench

Sequential AES SubBytes unit: replaces all 16 bytes of a 128-bit state with their S-box values using a single shared, externally instantiated `sbox_sync` (synchronous RAM S-box, 1-cycle read latency). It sits directly upstream of `sbox_sync`, driving its address, and consumes its registered output. It feeds the ShiftRows/MixColumns path inside the AES core. The S-box port stays outside so the core can time-share one ROM with key expansion.

---
 rtl/sub_bytes_seq.sv | 85 ++++++++
 tb/tb_sub_bytes_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: walks the 16 state bytes through one shared,
// externally instantiated synchronous S-box and reassembles the substituted state.
module sub_bytes_seq (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic [7:0]   sbox_a,
    input  logic [7:0]   sbox_y,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [127:0]   in_q, in_d;
    logic [127:0]   out_q, out_d;
    logic           done_q, done_d;
    logic [3:0]     rd_idx;
    logic [3:0]     wr_idx;

    // Byte k sits at bit offset 8*(15-k); for a 4-bit k, 15-k is simply ~k.
    always_comb begin
        rd_idx = cnt_q[4] ? 4'd15 : cnt_q[3:0];
        wr_idx = cnt_q[3:0] - 4'd1;
        sbox_a = (state_q == RUN) ? in_q[{~rd_idx, 3'b000} +: 8] : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = state_in;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // sbox_y trails the address by one edge, so it belongs to byte cnt-1.
                if (cnt_q != 5'd0) begin
                    out_d[{~wr_idx, 3'b000} +: 8] = sbox_y;
                end
                if (cnt_q[4]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            in_q    <= 128'd0;
            out_q   <= 128'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign state_out = out_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq with a registered S-box model and a scoreboard of
// expected substituted states checked on every done pulse.
module tb_sub_bytes_seq;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] state_in;
    logic [7:0]   sbox_a;
    logic [7:0]   sbox_y;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    int n_vec;
    int n_err;
    logic [127:0] sb_q[$];
    logic [7:0]   sbox_t [256];

    localparam logic [127:0] APPB_IN  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [127:0] APPB_OUT = 128'hD42711AEE0BF98F1B8B45DE51E415230;
    localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090A0B0C0D0E0F;

    sub_bytes_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .state_in  (state_in),
        .sbox_a    (sbox_a),
        .sbox_y    (sbox_y),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sbox_y = 8'h00;
    always @(posedge clk) sbox_y <= sbox_t[sbox_a];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) check("done_spurious", {127'd0, done}, 128'd0);
            else check("state_out", state_out, sb_q.pop_front());
        end
    end

    task automatic kick(input logic [127:0] d, input logic [127:0] exp);
        @(posedge clk); #1;
        state_in = d;
        start    = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start    = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_rise", {127'd0, busy}, 128'd1);
    endtask

    task automatic wait_done(input int exp_lat);
        int k;
        k = 0;
        do begin
            @(posedge clk); k++;
            @(negedge clk);
        end while (!done && k < 40);
        check("latency", k, exp_lat);
    endtask

    initial begin
        logic [127:0] va;
        logic [127:0] vb;
        int pulses;
        n_vec = 0; n_err = 0;
        reset_n = 1'b0; start = 1'b0; state_in = 128'd0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_f(i[7:0]);

        #3;
        check("por_out", state_out, 128'd0);
        check("por_ctl", {124'd0, busy, done, 2'b00}, 128'd0);
        check("por_addr", {120'd0, sbox_a}, 128'd0);
        @(negedge clk); reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("idle_pulses", pulses, 0);
        check("idle_out", state_out, 128'd0);
        check("idle_addr", {120'd0, sbox_a}, 128'd0);

        kick(APPB_IN, APPB_OUT);
        wait_done(17);
        check("idle_addr_done", {120'd0, sbox_a}, 128'd0);

        kick(128'd0, {16{8'h63}});
        wait_done(17);
        kick({16{8'hFF}}, {16{8'h16}});
        wait_done(17);

        kick(SEQ_IN, sub_state(SEQ_IN));
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("sbox_a_%0d", k), {120'd0, sbox_a}, {124'd0, (k > 15) ? 4'hF : k[3:0]});
            @(posedge clk);
        end
        @(negedge clk);
        check("seq_done", {127'd0, done}, 128'd1);
        check("seq_addr_idle", {120'd0, sbox_a}, 128'd0);

        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        kick(va, sub_state(va));
        repeat (4) @(posedge clk);
        #1; start = 1'b1; state_in = vb;
        @(posedge clk); #1; start = 1'b0;
        wait_done(12);

        kick(vb, sub_state(vb));
        repeat (16) @(posedge clk);
        #1; start = 1'b1; state_in = va;
        sb_q.push_back(sub_state(va));
        wait_done(1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {127'd0, busy}, 128'd1);
        wait_done(17);

        kick(SEQ_IN, sub_state(SEQ_IN));
        repeat (8) @(posedge clk);
        #2; reset_n = 1'b0;
        #1;
        check("rst_ctl", {126'd0, busy, done}, 128'd0);
        check("rst_out", state_out, 128'd0);
        check("rst_addr", {120'd0, sbox_a}, 128'd0);
        sb_q.delete();
        @(negedge clk); reset_n = 1'b1;
        kick(APPB_IN, APPB_OUT);
        wait_done(17);

        repeat (3) @(posedge clk);
        check("sb_left", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
